// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and types for the round-robin mux arbiter
package mux_arb_pkg;

   localparam int N_REQ = 4;

   typedef logic [1:0] src_t;

   // last_grant resets to the top index so requester 0 is first in line
   localparam src_t LAST_GRANT_RST = 2'd3;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotate-and-scan round-robin picker over four requesters
import mux_arb_pkg::*;

module rr_pick4 (
   input  logic [N_REQ-1:0] elig,
   input  src_t             last_grant,
   output logic             found,
   output src_t             winner
);

   src_t                   start;
   src_t                   offset;
   logic [2*N_REQ-1:0]     dbl;
   logic [N_REQ-1:0]       rot;

   // rotate so the slot after last_grant sits at bit 0, take the lowest set bit, rotate back
   always_comb begin
      start  = last_grant + 2'd1;
      dbl    = {elig, elig} >> start;
      rot    = dbl[N_REQ-1:0];
      found  = |rot;
      offset = 2'd0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            offset = src_t'(i);
         end
      end
      winner = start + offset;
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - four-way round-robin arbiter with a registered one-entry output
import mux_arb_pkg::*;

module mux_rr_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_en,
   input  logic [N_REQ-1:0] in_valid,
   input  logic [WIDTH-1:0] in_data [N_REQ],
   output logic [N_REQ-1:0] in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output src_t             out_src,
   input  logic             out_ready
);

   logic             found;
   src_t             winner;
   src_t             last_grant;
   logic             load;
   logic [N_REQ-1:0] elig;

   rr_pick4 u_pick (
      .elig       (elig),
      .last_grant (last_grant),
      .found      (found),
      .winner     (winner)
   );

   // accept a word whenever one is eligible and the output slot is free or draining;
   // reset blocks every handshake so nothing is lost into a register being cleared
   always_comb begin
      elig     = in_valid & req_en;
      load     = found & (!out_valid | out_ready) & !rst;
      in_ready = '0;
      if (load) begin
         in_ready[winner] = 1'b1;
      end
   end

   // output register and round-robin pointer; pointer only moves on an actual grant
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_src    <= '0;
         last_grant <= LAST_GRANT_RST;
      end else if (load) begin
         out_valid  <= 1'b1;
         out_data   <= in_data[winner];
         out_src    <= winner;
         last_grant <= winner;
      end else if (out_valid && out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one mux-selected output channel among four valid/ready requesters. Each cycle it picks one eligible requester, drives the internal 4:1 data mux select, and captures the winner's word into a one-entry output register. It sits in front of any single-consumer datapath that several producers must share, and gives one-cycle latency and full throughput.

## Interface
- `WIDTH`, 8: data width of every input word and of the output word.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous reset, active-high.
- `req_en`  input  4  static per-requester enable mask; bit i = 0 makes requester i ineligible.
- `in_valid`  input  4  bit i: requester i offers `in_data[i]`.
- `in_data`  input  4 x WIDTH  unpacked array of request words; `in_data[i]` belongs to requester i.
- `in_ready`  output  4  bit i: word of requester i accepted this cycle; at most one bit set.
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  WIDTH  output word.
- `out_src`  output  2  index of the requester that supplied `out_data`.
- `out_ready`  input  1  consumer accepts `out_data` this cycle.

## Operation
- Eligible requester: `in_valid[i] & req_en[i]`. `any_req` is the OR over all four.
- Output register state: EMPTY (`out_valid` = 0) or FULL (`out_valid` = 1).
- Load condition: `load = any_req & (!out_valid | out_ready)`.
- Winner: the first eligible index scanning upward, modulo 4, starting at `last_grant + 1`.
- On `load`:
  - `in_ready[winner]` = 1; all other bits are 0.
  - Next edge: `out_data` = `in_data[winner]`, `out_src` = winner, `out_valid` = 1, `last_grant` = winner.
- On `!load & out_valid & out_ready`: `out_valid` goes to 0 on the next edge. `out_data` and `out_src` hold their values.
- Otherwise all registers hold.
- `in_ready` is combinational from `in_valid`, `req_en`, `out_valid`, `out_ready` and `last_grant`. Upstream must not make `in_valid` depend on `in_ready`.
- `last_grant` updates only on a load. A requester that is not granted keeps its turn.
- Fairness: with all four requesting continuously and `out_ready` = 1, grants rotate 0,1,2,3,0,... No requester waits more than 3 transfers.
- Clearing `req_en[i]` while i is waiting removes i from arbitration from that cycle onward. A word already in the output register is unaffected.
- Simultaneous drain and load (FULL, `out_ready` = 1, `any_req`): the old word is consumed and the new word is loaded on the same edge, with no bubble.
- Backpressure (FULL, `out_ready` = 0): all `in_ready` = 0, and output registers are stable until `out_ready` rises.

## Timing
- Reset values (held while `rst` = 1, taking effect on the next edge): `out_valid` = 0, `out_data` = 0, `out_src` = 0, `last_grant` = 3, so requester 0 has first priority.
- While `rst` = 1, `in_ready` = 0.
- Reset asserted mid-transfer discards the held word. No handshake completes in that cycle.
- Latency: a word accepted in cycle t appears with `out_valid` = 1 in cycle t+1.
- Throughput: one word per cycle when `out_ready` stays high.
- `out_valid`, `out_data` and `out_src` are registered outputs. The only combinational path is the one into `in_ready`.

## Structure
- Package `mux_arb_pkg`:
  - `N_REQ` = 4;
  - `typedef logic [1:0] src_t`;
  - reset constant `LAST_GRANT_RST` = 2'd3.
- Sub-module `rr_pick4`: inputs are a 4-bit eligibility vector and `last_grant`; outputs are `found` and a `src_t` winner. It is purely combinational and rotation-based.
- The data path is a 4:1 mux on `in_data` indexed by the winner, feeding the output register.

## Test plan
- Reset, then `in_valid` = 4'b0001, `in_data[0]` = 8'hA5, `out_ready` = 1:
  - `in_ready` = 4'b0001 in the same cycle;
  - next cycle `out_valid` = 1, `out_data` = 8'hA5, `out_src` = 0.
- All four valid continuously with data 8'h10..8'h13, `out_ready` = 1:
  - `out_src` sequence is 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- Backpressure: FULL with `out_src` = 1, `out_ready` = 0 for 3 cycles, requesters 2 and 3 valid:
  - `in_ready` = 0 and outputs are stable for 3 cycles;
  - when `out_ready` rises, requester 2 wins the same cycle.
- Mask: `req_en` = 4'b1011, all valid, `out_ready` = 1:
  - grants are 0,1,3,0,1,3;
  - `in_ready[2]` is never 1.
- Drain without refill: FULL, `in_valid` = 0, `out_ready` = 1:
  - `out_valid` = 0 next cycle;
  - `out_data` keeps its last value.
- Reset mid-stream: assert `rst` while FULL with `out_src` = 2:
  - next cycle `out_valid` = 0;
  - after release, with all valid, the first grant is 0.
